// File: rtl/rca_pkg.sv
// Shared segment geometry helpers and mode encoding for the pipelined ripple-carry adder.
package rca_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  function automatic int seg_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int seg_lo(input int k, input int seg);
    return k * seg;
  endfunction

  // The last segment is clipped to the operand width, so it may be narrower.
  function automatic int seg_hi(input int k, input int seg, input int width);
    return (((k + 1) * seg < width) ? (k + 1) * seg : width) - 1;
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational ripple-carry slice of BITS bits; also exposes the carry into its top bit.
module rca_segment
  import rca_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] sum,
  output logic            cout,
  output logic            ctop
);

  logic [BITS:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < BITS; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[BITS];
  assign ctop = carry[BITS-1];

endmodule

// File: rtl/pipelined_ripple_carry_adder.sv
// Ripple-carry adder/subtractor split into STAGES carry-segmented register stages
// with a fully backpressured valid/ready pipeline.
module pipelined_ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int WIDTH  = 13,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_sub,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || seg_lo(STAGES - 1, SEG) >= WIDTH) begin : g_bad_params
    $error("pipelined_ripple_carry_adder: WIDTH/STAGES leave a segment empty");
  end

  mode_e            mode;
  logic [WIDTH-1:0] b_mod;
  logic             c0;

  assign mode  = mode_e'(i_sub);
  assign b_mod = (mode == SUB) ? ~i_add_term2 : i_add_term2;
  assign c0    = (mode == SUB) ? 1'b1 : i_carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = seg_lo(k, SEG);
    localparam int HI = seg_hi(k, SEG, WIDTH);
    localparam int NB = HI - LO + 1;

    logic [NB-1:0] seg_a, seg_b, seg_sum;
    logic          seg_cin, seg_cout, seg_ctop;
    logic          v_in, load, valid_q, c_q;
    logic [HI:0]   s_next, s_q;

    if (k == 0) begin : g_src
      assign seg_a   = i_add_term1[HI:0];
      assign seg_b   = b_mod[HI:0];
      assign seg_cin = c0;
      assign v_in    = i_valid;
      assign s_next  = seg_sum;
    end else begin : g_src
      assign seg_a   = g_stage[k-1].g_fwd.a_q[HI:LO];
      assign seg_b   = g_stage[k-1].g_fwd.b_q[HI:LO];
      assign seg_cin = g_stage[k-1].c_q;
      assign v_in    = g_stage[k-1].valid_q;
      assign s_next  = {seg_sum, g_stage[k-1].s_q};
    end

    rca_segment #(.BITS(NB)) u_seg (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (seg_cin),
      .sum  (seg_sum),
      .cout (seg_cout),
      .ctop (seg_ctop)
    );

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        valid_q <= 1'b0;
        s_q     <= '0;
        c_q     <= 1'b0;
      end else if (load) begin
        valid_q <= v_in;
        s_q     <= s_next;
        c_q     <= seg_cout;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI+1] a_q, b_q, a_next, b_next;

      if (k == 0) begin : g_rest
        assign a_next = i_add_term1[WIDTH-1:HI+1];
        assign b_next = b_mod[WIDTH-1:HI+1];
      end else begin : g_rest
        assign a_next = g_stage[k-1].g_fwd.a_q[WIDTH-1:HI+1];
        assign b_next = g_stage[k-1].g_fwd.b_q[WIDTH-1:HI+1];
      end

      // A stage may refill whenever it is empty or its contents move on this cycle.
      assign load = !valid_q || g_stage[k+1].load;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_next;
          b_q <= b_next;
        end
      end
    end else begin : g_out
      logic ovf_q;

      assign load = !valid_q || i_ready;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= seg_cout ^ seg_ctop;
        end
      end
    end
  end

  assign o_ready    = g_stage[0].load;
  assign o_valid    = g_stage[STAGES-1].valid_q;
  assign o_result   = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].s_q};
  assign o_overflow = g_stage[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_carry_adder.sv
// Scoreboard bench: directed checks on a 13-bit/4-stage instance plus random sweeps
// over several WIDTH/STAGES combinations, all against an arithmetic reference model.
module tb_pipelined_ripple_carry_adder;

  typedef struct {
    longint unsigned res;
    logic            ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectorCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, got, want);
    end
  endtask

  // Reference: unsigned sum / not-borrow plus signed range test of the true result.
  function automatic exp_t refModel(input int w, input longint unsigned a, input longint unsigned b,
                                    input logic sub, input logic cin);
    exp_t            e;
    longint unsigned full;
    longint          sa, sb, sr, hiLim, loLim;
    full  = 64'd1 << w;
    sa    = (a >= full / 2) ? longint'(a) - longint'(full) : longint'(a);
    sb    = (b >= full / 2) ? longint'(b) - longint'(full) : longint'(b);
    if (sub) begin
      e.res = ((a - b) & (full - 1)) | ((a >= b) ? full : 64'd0);
      sr    = sa - sb;
    end else begin
      e.res = a + b + (cin ? 64'd1 : 64'd0);
      sr    = sa + sb + (cin ? 1 : 0);
    end
    hiLim = longint'(full / 2) - 1;
    loLim = -longint'(full / 2);
    e.ovf = (sr > hiLim) || (sr < loLim);
    return e;
  endfunction

  // ---------------- main 13-bit / 4-stage instance ----------------
  logic        rst, inValid, dutReady, subMode, carryIn, resValid, sinkReady, overflow;
  logic [12:0] termA, termB;
  logic [13:0] result;

  pipelined_ripple_carry_adder #(.WIDTH(13), .STAGES(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (inValid),
    .o_ready     (dutReady),
    .i_add_term1 (termA),
    .i_add_term2 (termB),
    .i_sub       (subMode),
    .i_carry     (carryIn),
    .o_valid     (resValid),
    .i_ready     (sinkReady),
    .o_result    (result),
    .o_overflow  (overflow)
  );

  exp_t mainQ[$];
  exp_t pending;
  logic lastAccepted, lastSawValid;
  int   outCount;

  // One clock cycle: sample at the falling edge, score outputs, queue accepted inputs.
  task automatic stepCycle();
    @(negedge clk);
    lastSawValid = resValid;
    lastAccepted = inValid && dutReady;
    if (resValid) begin
      if (mainQ.size() == 0) begin
        checkOutput("unexpected_valid", 64'(resValid), 64'd0);
      end else begin
        checkOutput("result", 64'(result), mainQ[0].res);
        checkOutput("overflow", 64'(overflow), 64'(mainQ[0].ovf));
        if (sinkReady) begin
          void'(mainQ.pop_front());
          outCount++;
        end
      end
    end
    if (inValid && dutReady) mainQ.push_back(pending);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [12:0] a, input logic [12:0] b, input logic sub,
                               input logic cin, input logic [13:0] wantRes, input logic wantOvf,
                               input string tag);
    int lat;
    termA       = a;
    termB       = b;
    subMode     = sub;
    carryIn     = cin;
    inValid     = 1'b1;
    sinkReady   = 1'b1;
    pending.res = 64'(wantRes);
    pending.ovf = wantOvf;
    stepCycle();
    checkOutput({tag, "_accept"}, 64'(lastAccepted), 64'd1);
    inValid = 1'b0;
    lat     = 0;
    do begin
      stepCycle();
      lat++;
    end while (!lastSawValid && lat < 20);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic setRandomBeat();
    termA       = 13'($urandom());
    termB       = 13'($urandom());
    subMode     = 1'($urandom_range(0, 1));
    carryIn     = 1'($urandom_range(0, 1));
    pending     = refModel(13, 64'(termA), 64'(termB), subMode, carryIn);
  endtask

  task automatic drainMain();
    int cyc;
    inValid   = 1'b0;
    sinkReady = 1'b1;
    cyc       = 0;
    while (mainQ.size() > 0 && cyc < 100) begin
      stepCycle();
      cyc++;
    end
    checkOutput("drain_empty", 64'(mainQ.size()), 64'd0);
  endtask

  // ---------------- random sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 0) ? 13 : (g == 1) ? 13 : (g == 2) ? 8 : 32;
    localparam int S = (g == 0) ? 1  : (g == 1) ? 13 : (g == 2) ? 3 : 5;

    logic         sRst, sInValid, sReady, sSub, sCin, sOutValid, sSinkReady, sOvf;
    logic [W-1:0] sA, sB;
    logic [W:0]   sRes;
    exp_t         q[$];
    int           sent;
    int           cyc;
    logic         done = 1'b0;

    pipelined_ripple_carry_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .i_clk       (clk),
      .i_rst       (sRst),
      .i_valid     (sInValid),
      .o_ready     (sReady),
      .i_add_term1 (sA),
      .i_add_term2 (sB),
      .i_sub       (sSub),
      .i_carry     (sCin),
      .o_valid     (sOutValid),
      .i_ready     (sSinkReady),
      .o_result    (sRes),
      .o_overflow  (sOvf)
    );

    initial begin
      sRst       = 1'b1;
      sInValid   = 1'b0;
      sSinkReady = 1'b0;
      sA         = '0;
      sB         = '0;
      sSub       = 1'b0;
      sCin       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sRst = 1'b0;
      sent = 0;
      cyc  = 0;
      while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
        sInValid   = (sent < 1000) && ($urandom_range(0, 9) < 8);
        sA         = W'($urandom());
        sB         = W'($urandom());
        sSub       = 1'($urandom_range(0, 1));
        sCin       = 1'($urandom_range(0, 1));
        sSinkReady = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (sOutValid) begin
          if (q.size() == 0) begin
            checkOutput($sformatf("sweep%0d_unexpected_valid", g), 64'(sOutValid), 64'd0);
          end else begin
            checkOutput($sformatf("sweep%0d_result", g), 64'(sRes), q[0].res);
            checkOutput($sformatf("sweep%0d_overflow", g), 64'(sOvf), 64'(q[0].ovf));
            if (sSinkReady) void'(q.pop_front());
          end
        end
        if (sInValid && sReady) begin
          q.push_back(refModel(W, 64'(sA), 64'(sB), sSub, sCin));
          sent++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      checkOutput($sformatf("sweep%0d_sent", g), 64'(sent), 64'd1000);
      checkOutput($sformatf("sweep%0d_drained", g), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence on the main instance ----------------
  initial begin
    int cyc;
    int accepted;
    rst       = 1'b1;
    inValid   = 1'b0;
    sinkReady = 1'b0;
    termA     = '0;
    termB     = '0;
    subMode   = 1'b0;
    carryIn   = 1'b0;
    outCount  = 0;
    pending   = '{res: 64'd0, ovf: 1'b0};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_valid", 64'(resValid), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    checkOutput("reset_ready", 64'(dutReady), 64'd1);
    @(posedge clk);
    #1;

    applyStimulus(13'h1FFF, 13'h0001, 1'b0, 1'b0, 14'h2000, 1'b0, "wrap_add");
    applyStimulus(13'h0005, 13'h0007, 1'b1, 1'b0, 14'h1FFE, 1'b0, "borrow_sub");
    applyStimulus(13'h0FFF, 13'h0001, 1'b0, 1'b0, 14'h1000, 1'b1, "pos_ovf");
    applyStimulus(13'h1000, 13'h0001, 1'b1, 1'b0, 14'h2FFF, 1'b1, "neg_ovf");
    applyStimulus(13'h0AAA, 13'h0555, 1'b0, 1'b1, 14'h1000, 1'b1, "carry_in");
    applyStimulus(13'h0AAA, 13'h0555, 1'b1, 1'b1, 14'h2555, 1'b0, "sub_ignores_cin");

    // Stream of 10 beats against a 1,0,0,1 sink-ready pattern.
    outCount = 0;
    accepted = 0;
    cyc      = 0;
    while (accepted < 10 && cyc < 200) begin
      inValid   = 1'b1;
      setRandomBeat();
      sinkReady = (cyc % 4 == 0) || (cyc % 4 == 3);
      stepCycle();
      if (lastAccepted) accepted++;
      cyc++;
    end
    drainMain();
    checkOutput("stream_accepted", 64'(accepted), 64'd10);
    checkOutput("stream_delivered", 64'(outCount), 64'd10);

    // Fill with the sink stalled, then release it and refill in the same cycle.
    inValid   = 1'b1;
    sinkReady = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 4; i++) begin
      setRandomBeat();
      stepCycle();
      if (lastAccepted) accepted++;
    end
    checkOutput("fill_accepted", 64'(accepted), 64'd4);
    #1;
    checkOutput("full_ready_low", 64'(dutReady), 64'd0);
    sinkReady = 1'b1;
    #1;
    checkOutput("drain_fill_ready", 64'(dutReady), 64'd1);
    setRandomBeat();
    outCount = 0;
    stepCycle();
    checkOutput("drain_fill_accept", 64'(lastAccepted), 64'd1);
    checkOutput("drain_fill_output", 64'(outCount), 64'd1);
    drainMain();

    // Reset with three beats in flight: they must vanish.
    inValid   = 1'b1;
    sinkReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setRandomBeat();
      stepCycle();
    end
    inValid = 1'b0;
    rst     = 1'b1;
    stepCycle();
    rst = 1'b0;
    mainQ.delete();
    @(negedge clk);
    checkOutput("flush_valid", 64'(resValid), 64'd0);
    checkOutput("flush_ready", 64'(dutReady), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) stepCycle();
    applyStimulus(13'h0123, 13'h0456, 1'b0, 1'b0, 14'h0579, 1'b0, "post_reset");

    for (int i = 0; i < 60000; i++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done) break;
      @(posedge clk);
    end
    checkOutput("sweeps_finished",
                64'({g_sweep[3].done, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}), 64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_carry_adder.md
# pipelined_ripple_carry_adder

Parametrised, pipelined successor to the fixed-width combinational ripple-carry adders in the adder-classification generator set. The block splits a WIDTH-bit ripple chain into STAGES carry-segmented register stages. It adds add/subtract mode, carry-in and signed-overflow output. A valid/ready handshake with full backpressure lets it sit between streaming operand sources and result sinks in the batch test harnesses.

## Interface

Parameters:
- WIDTH, 13 — operand width in bits; must be ≥ 2.
- STAGES, 4 — number of pipeline segments; must satisfy 1 ≤ STAGES ≤ WIDTH.

Ports:
- i_clk  input  1  — single clock; all state on the rising edge.
- i_rst  input  1  — reset, synchronous and active-high.
- i_valid  input  1  — operand beat valid.
- o_ready  output  1  — block can accept an operand beat this cycle.
- i_add_term1  input  WIDTH  — operand A.
- i_add_term2  input  WIDTH  — operand B.
- i_sub  input  1  — 0 computes A+B+cin; 1 computes A−B as A+~B+1.
- i_carry  input  1  — carry-in; used only when i_sub=0.
- o_valid  output  1  — result beat valid.
- i_ready  input  1  — downstream accepts a result beat.
- o_result  output  WIDTH+1  — [WIDTH-1:0] is the sum; [WIDTH] is the carry-out. When i_sub=1, [WIDTH] is the not-borrow flag.
- o_overflow  output  1  — two's-complement signed overflow of the operation.

## Operation

- Segment width SEG = ceil(WIDTH/STAGES). Segment k covers bits [k·SEG, min((k+1)·SEG, WIDTH)−1]. The last segment may be narrower. Every segment must be non-empty; a parameter set that produces an empty segment is illegal and fails elaboration.
- Input preprocessing happens before stage 0: B' = i_sub ? ~B : B, and c0 = i_sub ? 1 : i_carry.
- Stage k takes the registered carry from stage k−1 (c0 for k=0) and ripples segment k.
- Each stage register holds:
  - the completed low result bits,
  - the unprocessed upper A and B' bits,
  - the segment carry-out,
  - the sign bits needed for overflow,
  - a valid flag.
- o_overflow = carry into the MSB XOR carry out of the MSB, taken from the last segment.
- Handshake: a beat transfers when valid and ready are both high.
  - Stage k loads when its register is empty or stage k+1 loads in the same cycle.
  - The last stage drains when i_ready=1.
  - o_ready = stage-0 load enable. Stage-0 load enable is a combinational function of occupancy and i_ready, so the i_ready→o_ready path is combinational.
- While backpressured (o_valid=1, i_ready=0), o_result, o_overflow and o_valid hold stable until the transfer.
- The pipeline does not reorder and never drops or duplicates a beat.

## Timing

- Reset: all stage valid flags = 0, o_valid = 0, o_result = 0, o_overflow = 0. o_ready = 1 in the first cycle after reset deasserts.
- Latency: a beat accepted in cycle t appears with o_valid=1 in cycle t+STAGES, provided no stall occurs.
- Throughput: 1 beat/cycle with i_ready held at 1.
- Full pipeline with i_ready=0: o_ready=0.
- Full pipeline with i_ready=1 in a cycle: a new beat is accepted in that same cycle (simultaneous drain and fill).
- Reset mid-operation: all in-flight beats are discarded, and no o_valid is emitted for them.
- STAGES=1: the block degenerates to a single registered adder with latency 1.
- Carry propagation per stage is bounded by a SEG-bit ripple.

## Structure

- Package rca_pkg:
  - function seg_width(WIDTH, STAGES) returning SEG;
  - localparam-style helpers for segment low/high bit indices;
  - typedef for the add/sub mode encoding (ADD=0, SUB=1).
- Sub-module rca_segment: combinational ripple of a parametrised bit count. Inputs are a, b and cin. Outputs are sum, cout and the carry into its top bit (used for overflow). It is instantiated once per stage.
- The top level holds the stage registers and valid/ready control; it contains no arithmetic beyond B' inversion.

## Test plan

- WIDTH=13, STAGES=4, A=13'h1FFF, B=1, i_sub=0, i_carry=0 → after 4 cycles, o_result=14'h2000, o_overflow=0.
- i_sub=1, A=5, B=7 → o_result=14'h1FFE (bit13=0, i.e. borrow), o_overflow=0.
- A=13'h0FFF, B=1, i_sub=0 → o_result=14'h1000, o_overflow=1. Then A=13'h1000, B=1, i_sub=1 → o_result=14'h2FFF, o_overflow=1.
- Stream 10 consecutive beats with i_ready toggling 1,0,0,1,… → every sum arrives in order exactly once, and o_result stays stable while stalled.
- Assert i_rst with 3 beats in flight → o_valid stays 0 the next cycle and o_ready=1. The next accepted beat yields the correct result after 4 cycles.
- Sweep (WIDTH, STAGES) ∈ {(13,1), (13,13), (8,3), (32,5)} with 1000 random beats each, including random i_carry and i_sub, against a reference model.
